// File: rtl/scene_compositor.sv
// rtl/scene_compositor.sv - per-pixel map/character read scheduler and compositor
module scene_compositor #(
    parameter int           MAP_W    = 1024,
    parameter int           MAP_H    = 1152,
    parameter int           SCR_W    = 640,
    parameter int           SCR_H    = 480,
    parameter int           CHAR_W   = 16,
    parameter int           CHAR_H   = 20,
    parameter int           CHAR_X0  = 312,
    parameter int           CHAR_Y0  = 230,
    parameter int           ANIM_DIV = 8,
    parameter logic [4:0]   TRANSP   = 5'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pixel_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        cam_req,
    input  logic [10:0] cam_x_req,
    input  logic [10:0] cam_y_req,
    output logic        cam_ack,
    input  logic [1:0]  facing,
    input  logic        walking,
    output logic [20:0] map_read_address,
    input  logic [4:0]  map_data,
    output logic [12:0] char_read_address,
    input  logic [4:0]  char_data,
    output logic [4:0]  pix_index,
    output logic        pix_valid
);

    localparam logic [10:0] CAM_X_MAX = 11'(MAP_W - SCR_W);
    localparam logic [10:0] CAM_Y_MAX = 11'(MAP_H - SCR_H);
    localparam logic [9:0]  CX0       = 10'(CHAR_X0);
    localparam logic [9:0]  CX1       = 10'(CHAR_X0 + CHAR_W);
    localparam logic [9:0]  CY0       = 10'(CHAR_Y0);
    localparam logic [9:0]  CY1       = 10'(CHAR_Y0 + CHAR_H);
    localparam int          DW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    logic [10:0]   cam_x_q, cam_x_d, cam_y_q, cam_y_d;
    logic [10:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic          pend_flag_q, pend_flag_d;
    logic          cam_ack_q, cam_ack_d;
    logic [1:0]    fac_q, fac_d;
    logic          walk_q, walk_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    phase_q, phase_d;
    logic [20:0]   map_addr_q, map_addr_d;
    logic [12:0]   char_addr_q, char_addr_d;
    logic          in1_q, in1_d, v1_q, v1_d;
    logic          in2_q, in2_d, v2_q, v2_d;
    logic [4:0]    pix_index_q, pix_index_d;
    logic          pix_valid_q, pix_valid_d;

    logic          capture;
    logic [10:0]   clamp_x, clamp_y;
    logic [10:0]   xsum, ysum;
    logic [9:0]    dx, dy;
    logic [1:0]    step;
    logic [3:0]    frame;

    always_comb begin
        capture     = cam_req && !cam_ack_q;
        clamp_x     = (cam_x_req > CAM_X_MAX) ? CAM_X_MAX : cam_x_req;
        clamp_y     = (cam_y_req > CAM_Y_MAX) ? CAM_Y_MAX : cam_y_req;

        cam_x_d     = cam_x_q;
        cam_y_d     = cam_y_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_flag_d = pend_flag_q;
        cam_ack_d   = capture;

        // Apply uses the pre-edge pending values, so a same-cycle capture stays pending.
        if (frame_start && pend_flag_q) begin
            cam_x_d     = pend_x_q;
            cam_y_d     = pend_y_q;
            pend_flag_d = 1'b0;
        end
        if (capture) begin
            pend_x_d    = clamp_x;
            pend_y_d    = clamp_y;
            pend_flag_d = 1'b1;
        end

        fac_d   = frame_start ? facing  : fac_q;
        walk_d  = frame_start ? walking : walk_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (!walk_q) begin
            div_d   = '0;
            phase_d = 2'd0;
        end else if (frame_start) begin
            if (div_q == DIV_LAST) begin
                div_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                div_d   = div_q + 1'b1;
            end
        end

        case (phase_q)
            2'd1:    step = 2'd1;
            2'd3:    step = 2'd2;
            default: step = 2'd0;
        endcase
        if (!walk_q) begin
            step = 2'd0;
        end
        frame = ({2'b00, fac_q} * 4'd3) + {2'b00, step};

        xsum  = {1'b0, DrawX} + cam_x_q;
        ysum  = {1'b0, DrawY} + cam_y_q;
        dx    = DrawX - CX0;
        dy    = DrawY - CY0;
        in1_d = (DrawX >= CX0) && (DrawX < CX1) && (DrawY >= CY0) && (DrawY < CY1);
        v1_d  = pixel_valid;

        map_addr_d  = 21'(32'(ysum) * MAP_W + 32'(xsum));
        char_addr_d = in1_d ? 13'(32'(frame) * (CHAR_W * CHAR_H) + 32'(dy) * CHAR_W + 32'(dx))
                            : 13'd0;

        // RAM data arrives one edge after the address registers; flags ride alongside.
        in2_d       = in1_q;
        v2_d        = v1_q;
        pix_valid_d = v2_q;
        if (!v2_q) begin
            pix_index_d = 5'd0;
        end else if (in2_q && (char_data != TRANSP)) begin
            pix_index_d = char_data;
        end else begin
            pix_index_d = map_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cam_x_q     <= '0;
            cam_y_q     <= '0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_flag_q <= 1'b0;
            cam_ack_q   <= 1'b0;
            fac_q       <= '0;
            walk_q      <= 1'b0;
            div_q       <= '0;
            phase_q     <= '0;
            map_addr_q  <= '0;
            char_addr_q <= '0;
            in1_q       <= 1'b0;
            v1_q        <= 1'b0;
            in2_q       <= 1'b0;
            v2_q        <= 1'b0;
            pix_index_q <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            cam_x_q     <= cam_x_d;
            cam_y_q     <= cam_y_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_flag_q <= pend_flag_d;
            cam_ack_q   <= cam_ack_d;
            fac_q       <= fac_d;
            walk_q      <= walk_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            map_addr_q  <= map_addr_d;
            char_addr_q <= char_addr_d;
            in1_q       <= in1_d;
            v1_q        <= v1_d;
            in2_q       <= in2_d;
            v2_q        <= v2_d;
            pix_index_q <= pix_index_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign cam_ack           = cam_ack_q;
    assign map_read_address  = map_addr_q;
    assign char_read_address = char_addr_q;
    assign pix_index         = pix_index_q;
    assign pix_valid         = pix_valid_q;

endmodule

// File: tb/tb_scene_compositor.sv
// tb/tb_scene_compositor.sv - directed self-checking bench for scene_compositor
module tb_scene_compositor;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pixel_valid = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        frame_start = 1'b0;
    logic        cam_req = 1'b0;
    logic [10:0] cam_x_req = '0;
    logic [10:0] cam_y_req = '0;
    logic        cam_ack;
    logic [1:0]  facing = '0;
    logic        walking = 1'b0;
    logic [20:0] map_read_address;
    logic [4:0]  map_data = '0;
    logic [12:0] char_read_address;
    logic [4:0]  char_data = '0;
    logic [4:0]  pix_index;
    logic        pix_valid;
    logic [4:0]  char_fill = '0;
    int          checks = 0;
    int          failures = 0;

    scene_compositor dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .pixel_valid       (pixel_valid),
        .DrawX             (DrawX),
        .DrawY             (DrawY),
        .frame_start       (frame_start),
        .cam_req           (cam_req),
        .cam_x_req         (cam_x_req),
        .cam_y_req         (cam_y_req),
        .cam_ack           (cam_ack),
        .facing            (facing),
        .walking           (walking),
        .map_read_address  (map_read_address),
        .map_data          (map_data),
        .char_read_address (char_read_address),
        .char_data         (char_data),
        .pix_index         (pix_index),
        .pix_valid         (pix_valid)
    );

    always #5 Clk = ~Clk;

    // Registered-read RAM models: map returns the low address bits, character returns a fill value.
    always @(posedge Clk) begin
        map_data  <= map_read_address[4:0];
        char_data <= char_fill;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic do_cam(input string tag, input int x, input int y);
        cam_x_req = 11'(x);
        cam_y_req = 11'(y);
        cam_req   = 1'b1;
        tick();
        check({tag, "_ack"}, 32'(cam_ack), 1);
        cam_req = 1'b0;
        tick();
        check({tag, "_ack_drop"}, 32'(cam_ack), 0);
    endtask

    task automatic run_pixel(input string tag, input int x, input int y,
                             input int exp_map, input int exp_char, input int exp_pix);
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        check({tag, "_map_addr"}, 32'(map_read_address), exp_map);
        check({tag, "_char_addr"}, 32'(char_read_address), exp_char);
        tick();
        tick();
        check({tag, "_pix_valid"}, 32'(pix_valid), 1);
        check({tag, "_pix_index"}, 32'(pix_index), exp_pix);
    endtask

    initial begin
        cam_req   = 1'b1;
        cam_x_req = 11'd2000;
        cam_y_req = 11'd2000;
        tick();
        check("rst_ack", 32'(cam_ack), 0);
        check("rst_map_addr", 32'(map_read_address), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        tick();
        check("rst_ack2", 32'(cam_ack), 0);
        check("rst_pix_index", 32'(pix_index), 0);
        Reset = 1'b0;
        tick();
        check("post_rst_ack", 32'(cam_ack), 1);
        cam_req = 1'b0;
        tick();
        check("post_rst_ack_drop", 32'(cam_ack), 0);
        pulse_fs();
        run_pixel("rst_cam", 5, 0, 672 * 1024 + 389, 0, 5);
        tick();
        check("idle_pix_valid", 32'(pix_valid), 0);
        check("idle_pix_index", 32'(pix_index), 0);

        do_cam("clamp", 2000, 2000);
        do_cam("last", 5, 7);
        pulse_fs();
        run_pixel("last_wins", 0, 0, 7173, 0, 5);

        facing  = 2'd2;
        walking = 1'b0;
        do_cam("scroll", 100, 50);
        pulse_fs();
        run_pixel("scroll", 10, 20, 71790, 0, 14);

        char_fill = 5'd0;
        run_pixel("transp", 313, 231, 288157, 1937, 29);
        char_fill = 5'd9;
        run_pixel("opaque", 313, 231, 288157, 1937, 9);
        run_pixel("box_right_edge", 327, 231, 288171, 1951, 9);
        run_pixel("box_right_out", 328, 231, 288172, 0, 12);
        run_pixel("box_bottom_out", 313, 250, 307613, 0, 29);

        char_fill = 5'd0;
        facing    = 2'd0;
        walking   = 1'b1;
        pulse_fs();
        run_pixel("anim0", 312, 230, 287132, 0, 28);
        for (int i = 0; i < 7; i++) pulse_fs();
        run_pixel("anim7", 312, 230, 287132, 0, 28);
        pulse_fs();
        run_pixel("anim8", 312, 230, 287132, 320, 28);
        for (int i = 0; i < 8; i++) pulse_fs();
        run_pixel("anim16", 312, 230, 287132, 0, 28);
        for (int i = 0; i < 8; i++) pulse_fs();
        run_pixel("anim24", 312, 230, 287132, 640, 28);
        for (int i = 0; i < 8; i++) pulse_fs();
        run_pixel("anim32", 312, 230, 287132, 0, 28);
        for (int i = 0; i < 8; i++) pulse_fs();
        run_pixel("anim40", 312, 230, 287132, 320, 28);
        walking = 1'b0;
        pulse_fs();
        run_pixel("anim_stop", 312, 230, 287132, 0, 28);

        do_cam("sim_old", 20, 30);
        cam_x_req   = 11'd40;
        cam_y_req   = 11'd60;
        cam_req     = 1'b1;
        frame_start = 1'b1;
        tick();
        check("sim_ack", 32'(cam_ack), 1);
        cam_req     = 1'b0;
        frame_start = 1'b0;
        tick();
        run_pixel("sim_old_applied", 0, 0, 30740, 0, 20);
        pulse_fs();
        run_pixel("sim_new_applied", 0, 0, 61480, 0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scene_compositor.md
# scene_compositor

Per-pixel read scheduler and compositor for the two sprite RAMs: the Violet City map RAM and the Ethan character RAM. For each VGA pixel it computes a scrolled map address and an animated character-frame address, issues both reads in the same cycle, and absorbs the RAMs' 1-cycle registered read latency. It then merges the results with a transparency key and emits a 5-bit palette index to the palette/VGA output stage. Camera position changes use a req/ack handshake from game logic and take effect only at frame boundaries, so a frame never tears.

## Interface
- MAP_W, 1024: map width in pixels; power of two.
- MAP_H, 1152: map height in pixels.
- SCR_W, 640 / SCR_H, 480: visible screen size.
- CHAR_W, 16 / CHAR_H, 20: character frame size in pixels.
- CHAR_X0, 312 / CHAR_Y0, 230: screen position of the character's top-left corner.
- ANIM_DIV, 8: number of frame_start pulses per walk-animation step.
- TRANSP, 5'd0: transparent palette index in character data.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- pixel_valid  in  1  DrawX/DrawY denote a visible pixel this cycle.
- DrawX  in  10  screen x.
- DrawY  in  10  screen y.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- cam_req  in  1  camera update request; held until cam_ack.
- cam_x_req  in  11  requested camera x.
- cam_y_req  in  11  requested camera y.
- cam_ack  out  1  one-cycle acknowledge.
- facing  in  2  0 down, 1 up, 2 left, 3 right.
- walking  in  1  selects walk animation.
- map_read_address  out  21  map RAM read address.
- map_data  in  5  map RAM data_Out.
- char_read_address  out  13  character RAM read address.
- char_data  in  5  character RAM data_Out.
- pix_index  out  5  composited palette index.
- pix_valid  out  1  pix_index corresponds to a visible pixel.

## Operation
- Camera registers cam_x and cam_y are active; pend_x, pend_y and pend_flag hold a pending update.
- Capture rule:
  - When cam_req=1 and cam_ack=0, clamp cam_x_req to at most MAP_W-SCR_W (384) and cam_y_req to at most MAP_H-SCR_H (672).
  - Write the clamped values to pend_x/pend_y, set pend_flag, and assert cam_ack for exactly one cycle.
  - A second capture before frame_start overwrites the pending values; last request wins.
- Apply rule: on frame_start with pend_flag=1, copy pend_x/pend_y into cam_x/cam_y and clear pend_flag.
- Capture and frame_start in the same cycle: frame_start applies the values pending before that edge. The newly captured values stay pending and pend_flag remains 1.
- facing and walking are sampled only on frame_start, into fac_r and walk_r.
- Animation:
  - When walk_r=0, step=0 and the divider is reset.
  - When walk_r=1, a divider counts frame_start pulses 0..ANIM_DIV-1. On wrap, the phase advances through 0,1,2,3 and wraps to 0.
  - step is taken from phase via the sequence 0,1,0,2.
  - Frame index = fac_r*3 + step, range 0..11.
- Address generation:
  - map_read_address = {DrawY+cam_y, DrawX+cam_x}[20:0], i.e. (DrawY+cam_y)*MAP_W + (DrawX+cam_x).
  - The character box is inside when CHAR_X0 ≤ DrawX < CHAR_X0+CHAR_W and CHAR_Y0 ≤ DrawY < CHAR_Y0+CHAR_H.
  - Inside the box: char_read_address = frame*CHAR_W*CHAR_H + (DrawY-CHAR_Y0)*CHAR_W + (DrawX-CHAR_X0).
  - Outside the box: char_read_address = 0.
- Composite:
  - pix_index = char_data when the delayed inside-flag=1 and char_data≠TRANSP; otherwise map_data.
  - pix_index = 0 whenever pix_valid=0.
- Reset: all outputs 0; cam, pend, pend_flag, fac_r, walk_r, divider and phase all 0; pipeline valid bits cleared.
- A request in flight during reset is lost. A requester still holding cam_req after reset is captured on the first non-reset cycle.

## Timing
- Pipeline stages:
  - Stage 1 (edge after input cycle N): addresses, inside-flag and valid are registered. Address outputs are driven from these registers.
  - Stage 2 (edge N+2): the RAMs register their data; inside-flag and valid are delayed alongside.
  - Stage 3 (edge N+3): pix_index and pix_valid are registered.
- Total latency: 3 cycles from DrawX/DrawY to pix_index. Throughput: 1 pixel per cycle with no stalls.
- cam_ack rises in the cycle after cam_req is first seen high. A cam_req still high in the cycle after ack (requester late to drop) causes a recapture two cycles later; requesters must drop cam_req on ack.
- Camera and animation changes are visible at the first pixel following the frame_start edge.

## Test plan
- Reset: assert Reset for 2 cycles with cam_req=1 → all outputs 0 during reset; cam_ack=1 one cycle after release; after the next frame_start, cam=(requested, clamped) values.
- Scroll: request cam=(100,50), pulse frame_start, drive DrawX=10, DrawY=20 → map_read_address=70*1024+110=71790 one cycle later; pix_index=map_data 3 cycles after input.
- Clamp/last-wins: request (2000,2000), then (5,7) before frame_start → ack each once; after frame_start cam=(5,7). With only the first request, cam=(384,672).
- Transparency: walking=0, facing=2, DrawX=313, DrawY=231 → char_read_address=6*320+17=1937. char_data=0 → pix_index=map_data; char_data=9 → pix_index=9. DrawX=328 → char_read_address=0 and map shown.
- Animation: walking=1, facing=0, ANIM_DIV=8 → step sequence 0,1,0,2 changes every 8 frame_starts. Dropping walking resets to step 0 at the next frame_start.
- Simultaneous: capture and frame_start in the same cycle → old pending applied; new values applied at the following frame_start.
